csr_file: RTL and testbench

- Machine-mode control/status register file for the 5-stage RV32I pipeline core.
- The memory-access stage reads a CSR combinationally by address.
- The same stage writes a CSR through a registered write port.
- Trap vector (mtvec) and exception return PC (mepc) are exported continuously for trap entry and mret redirection.

---
 rtl/csr_pkg.sv | 46 ++++
 rtl/csr_cycle_counter.sv | 32 +++
 rtl/csr_file.sv | 90 +++++++++
 tb/tb_csr_file.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared CSR constants: addresses, reset values and write masks.
package csr_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 12;

  typedef logic [ADDR_W-1:0] csr_addr_t;

  // Machine-mode CSR addresses
  localparam csr_addr_t CSR_MSTATUS   = 12'h300;
  localparam csr_addr_t CSR_MISA      = 12'h301;
  localparam csr_addr_t CSR_MIE       = 12'h304;
  localparam csr_addr_t CSR_MTVEC     = 12'h305;
  localparam csr_addr_t CSR_MSCRATCH  = 12'h340;
  localparam csr_addr_t CSR_MEPC      = 12'h341;
  localparam csr_addr_t CSR_MCAUSE    = 12'h342;
  localparam csr_addr_t CSR_MTVAL     = 12'h343;
  localparam csr_addr_t CSR_MIP       = 12'h344;
  localparam csr_addr_t CSR_MCYCLE    = 12'hB00;
  localparam csr_addr_t CSR_MCYCLEH   = 12'hB80;
  localparam csr_addr_t CSR_CYCLE     = 12'hC00;
  localparam csr_addr_t CSR_CYCLEH    = 12'hC80;
  localparam csr_addr_t CSR_MVENDORID = 12'hF11;
  localparam csr_addr_t CSR_MARCHID   = 12'hF12;
  localparam csr_addr_t CSR_MIMPID    = 12'hF13;
  localparam csr_addr_t CSR_MHARTID   = 12'hF14;

  // Reset values (MPP hardwired to machine mode)
  localparam logic [DATA_W-1:0] MSTATUS_RST = 32'h0000_1800;

  // Write masks: a 1 marks a bit that software may change
  localparam logic [DATA_W-1:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [DATA_W-1:0] MIE_WMASK     = 32'h0000_0888;
  localparam logic [DATA_W-1:0] MTVEC_WMASK   = 32'hFFFF_FFFC;
  localparam logic [DATA_W-1:0] MEPC_WMASK    = 32'hFFFF_FFFC;

  // Apply a write mask, then OR in any hardwired-one bits
  function automatic logic [DATA_W-1:0] csr_masked(
    input logic [DATA_W-1:0] data,
    input logic [DATA_W-1:0] wmask,
    input logic [DATA_W-1:0] fixed_ones
  );
    return (data & wmask) | fixed_ones;
  endfunction

endpackage

// File: rtl/csr_cycle_counter.sv
// 64-bit free-running cycle counter with independent low/high word loads.
module csr_cycle_counter
  import csr_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_lo,
  input  logic              ld_hi,
  input  logic [DATA_W-1:0] ld_data,
  output logic [63:0]       count
);

  logic [DATA_W-1:0] lo_q;
  logic [DATA_W-1:0] hi_q;
  logic              carry;

  // The high word always takes the carry from the pre-load low word
  assign carry = &lo_q;
  assign count = {hi_q, lo_q};

  // Increment every cycle; a load replaces its word instead of counting it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lo_q <= '0;
      hi_q <= '0;
    end else begin
      lo_q <= ld_lo ? ld_data : lo_q + 32'd1;
      hi_q <= ld_hi ? ld_data : hi_q + {{(DATA_W-1){1'b0}}, carry};
    end
  end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file: combinational read port, registered write port.
module csr_file
  import csr_pkg::*;
#(
  parameter logic [DATA_W-1:0] HART_ID    = 32'd0,
  parameter logic [DATA_W-1:0] MISA_VALUE = 32'h4000_0100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wb_csr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic [DATA_W-1:0] out_trap_vec,
  output logic [DATA_W-1:0] out_exception_pc
);

  logic [DATA_W-1:0] mstatus_q;
  logic [DATA_W-1:0] mie_q;
  logic [DATA_W-1:0] mtvec_q;
  logic [DATA_W-1:0] mscratch_q;
  logic [DATA_W-1:0] mepc_q;
  logic [DATA_W-1:0] mcause_q;
  logic [DATA_W-1:0] mtval_q;
  logic [63:0]       cycle;
  logic              ld_lo;
  logic              ld_hi;

  assign ld_lo = wb_csr && (write_addr == CSR_MCYCLE);
  assign ld_hi = wb_csr && (write_addr == CSR_MCYCLEH);

  csr_cycle_counter u_cycle (
    .clk     (clk),
    .reset   (reset),
    .ld_lo   (ld_lo),
    .ld_hi   (ld_hi),
    .ld_data (in_data),
    .count   (cycle)
  );

  // Writable machine registers; unknown or read-only addresses drop the write
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mstatus_q  <= MSTATUS_RST;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else if (wb_csr) begin
      case (write_addr)
        CSR_MSTATUS:  mstatus_q  <= csr_masked(in_data, MSTATUS_WMASK, MSTATUS_RST);
        CSR_MIE:      mie_q      <= csr_masked(in_data, MIE_WMASK, '0);
        CSR_MTVEC:    mtvec_q    <= csr_masked(in_data, MTVEC_WMASK, '0);
        CSR_MSCRATCH: mscratch_q <= in_data;
        CSR_MEPC:     mepc_q     <= csr_masked(in_data, MEPC_WMASK, '0);
        CSR_MCAUSE:   mcause_q   <= in_data;
        CSR_MTVAL:    mtval_q    <= in_data;
        default:      ;
      endcase
    end
  end

  // Read mux: reflects register state before any same-cycle write lands
  always_comb begin
    out_data = '0;
    case (addr)
      CSR_MSTATUS:  out_data = mstatus_q;
      CSR_MISA:     out_data = MISA_VALUE;
      CSR_MIE:      out_data = mie_q;
      CSR_MTVEC:    out_data = mtvec_q;
      CSR_MSCRATCH: out_data = mscratch_q;
      CSR_MEPC:     out_data = mepc_q;
      CSR_MCAUSE:   out_data = mcause_q;
      CSR_MTVAL:    out_data = mtval_q;
      CSR_MCYCLE,
      CSR_CYCLE:    out_data = cycle[31:0];
      CSR_MCYCLEH,
      CSR_CYCLEH:   out_data = cycle[63:32];
      CSR_MHARTID:  out_data = HART_ID;
      default:      out_data = '0;
    endcase
  end

  assign out_trap_vec     = mtvec_q;
  assign out_exception_pc = mepc_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed bench for csr_file with an expected-value scoreboard queue.
module tb_csr_file;

  localparam logic [31:0] HART_ID    = 32'd0;
  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

  logic        clk;
  logic        reset;
  logic        wb_csr;
  logic [11:0] addr;
  logic [11:0] write_addr;
  logic [31:0] in_data;
  logic [31:0] out_data;
  logic [31:0] out_trap_vec;
  logic [31:0] out_exception_pc;

  logic [31:0] exp_q[$];
  int          n_pass;
  int          n_total;

  csr_file #(
    .HART_ID    (HART_ID),
    .MISA_VALUE (MISA_VALUE)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .wb_csr           (wb_csr),
    .addr             (addr),
    .write_addr       (write_addr),
    .in_data          (in_data),
    .out_data         (out_data),
    .out_trap_vec     (out_trap_vec),
    .out_exception_pc (out_exception_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: expected values are queued as stimulus is driven
  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    n_total++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: observed %h, scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, e);
    end
  endtask

  task automatic rd(input logic [11:0] a, input string tag);
    addr = a;
    #1;
    chk(tag, out_data);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    wb_csr     = 1'b1;
    write_addr = a;
    in_data    = d;
    tick();
    wb_csr     = 1'b0;
    in_data    = '0;
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b0; wb_csr = 1'b0; addr = '0; write_addr = '0; in_data = '0;
    tick(); tick();
    reset = 1'b1;
    tick();

    // Dirty some state, then assert reset between clock edges
    wr(12'h305, 32'h0000_0100);
    wr(12'h341, 32'h0000_0200);
    wr(12'h300, 32'hFFFF_FFFF);
    #2;
    reset = 1'b0;
    addr  = 12'h300;
    expect_val(32'h0); expect_val(32'h0);
    #1;
    chk("rst_trap_vec", out_trap_vec);
    chk("rst_exc_pc", out_exception_pc);
    expect_val(32'h0000_1800); rd(12'h300, "rst_mstatus");
    expect_val(MISA_VALUE);    rd(12'h301, "rst_misa");
    expect_val(32'h0);         rd(12'hB00, "rst_mcycle");
    // A write attempted while reset is held must be discarded
    @(negedge clk);
    wr(12'h305, 32'h0000_4444);
    reset = 1'b1;
    expect_val(32'h0); #1; chk("rst_discard_write", out_trap_vec);

    // Trap vector / exception PC, and old value during the write cycle
    wb_csr = 1'b1; write_addr = 12'h305; in_data = 32'h8000_0107;
    expect_val(32'h0); rd(12'h305, "mtvec_old_during_write");
    tick();
    wr(12'h341, 32'h0000_2003);
    expect_val(32'h8000_0104); expect_val(32'h0000_2000);
    #1;
    chk("trap_vec", out_trap_vec);
    chk("exception_pc", out_exception_pc);

    // mstatus / mie masking, read-only and unmapped addresses
    wr(12'h300, 32'hFFFF_FFFF); expect_val(32'h0000_1888); rd(12'h300, "mstatus_ones");
    wr(12'h300, 32'h0);         expect_val(32'h0000_1800); rd(12'h300, "mstatus_zero");
    wr(12'h304, 32'hFFFF_FFFF); expect_val(32'h0000_0888); rd(12'h304, "mie_mask");
    wr(12'h301, 32'h1234_5678); expect_val(MISA_VALUE);    rd(12'h301, "misa_ro");
    wr(12'hF14, 32'h1234_5678); expect_val(HART_ID);       rd(12'hF14, "mhartid_ro");
    wr(12'h7C0, 32'h1234_5678); expect_val(32'h0);         rd(12'h7C0, "unmapped");
    wr(12'h344, 32'hFFFF_FFFF); expect_val(32'h0);         rd(12'h344, "mip_zero");
    wr(12'h342, 32'h8000_000B); expect_val(32'h8000_000B); rd(12'h342, "mcause");

    // mscratch holds while the write enable is low
    wr(12'h340, 32'hDEAD_BEEF);
    write_addr = 12'h340; in_data = 32'h0; wb_csr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_val(32'hDEAD_BEEF); rd(12'h340, "mscratch_hold");
    end

    // Low-word wrap carries into the high word
    wr(12'hB80, 32'h0000_0005);
    wr(12'hB00, 32'hFFFF_FFFE);
    expect_val(32'hFFFF_FFFE); rd(12'hB00, "mcycle_loaded");
    tick();
    expect_val(32'hFFFF_FFFF); rd(12'hB00, "mcycle_ff");
    expect_val(32'hFFFF_FFFF); rd(12'hC00, "cycle_alias_ff");
    tick();
    expect_val(32'h0);         rd(12'hB00, "mcycle_wrap");
    expect_val(32'h0);         rd(12'hC00, "cycle_alias_wrap");
    expect_val(32'h0000_0006); rd(12'hB80, "mcycleh_carry");
    expect_val(32'h0000_0006); rd(12'hC80, "cycleh_alias");

    // Writing the low word keeps the carry of the pre-write value
    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB00, 32'h0000_0010);
    expect_val(32'h0000_0010); rd(12'hB00, "mcycle_write_lo");
    expect_val(32'h0000_0007); rd(12'hB80, "mcycleh_prewrite_carry");

    // Full 64-bit wrap
    wr(12'hB80, 32'hFFFF_FFFF);
    wr(12'hB00, 32'hFFFF_FFFE);
    tick(); tick();
    expect_val(32'h0); rd(12'hB00, "wrap64_lo");
    expect_val(32'h0); rd(12'hB80, "wrap64_hi");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
